// File: rtl/tipi_nib_seq.sv
// tipi_nib_seq: Pi nibble-bus frame sequencer for the TIPI TD/TC/RD/RC registers.
// Ports: clk, r_reset, Pi side (r_clk, r_nibrst, r_nib_i/o, r_nib_oe), td/tc in, rd/rc out, strobes, busy, frame_err.
module tipi_nib_seq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       r_clk,
  input  logic       r_nibrst,
  input  logic [3:0] r_nib_i,
  output logic [3:0] r_nib_o,
  output logic       r_nib_oe,
  input  logic [7:0] td,
  input  logic [7:0] tc,
  output logic [7:0] rd,
  output logic [7:0] rc,
  output logic       rd_wr_stb,
  output logic       rc_wr_stb,
  output logic       td_rd_stb,
  output logic       tc_rd_stb,
  output logic       busy,
  output logic       frame_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RHI  = 3'd1;
  localparam logic [2:0] RLO  = 3'd2;
  localparam logic [2:0] WHI  = 3'd3;
  localparam logic [2:0] WLO  = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  logic [SYNC_STAGES-1:0]      clk_sync;
  logic [SYNC_STAGES-1:0]      rst_sync;
  logic [SYNC_STAGES-1:0][3:0] nib_sync;
  logic                        clk_q;

  // Synchronisers carry no reset: clearing clk_q while the Pi
  // holds r_clk high would fake a rising edge afterwards.
  always_ff @(posedge clk) begin
    clk_sync <= {clk_sync[SYNC_STAGES-2:0], r_clk};
    rst_sync <= {rst_sync[SYNC_STAGES-2:0], r_nibrst};
    nib_sync <= {nib_sync[SYNC_STAGES-2:0], r_nib_i};
    clk_q    <= clk_sync[SYNC_STAGES-1];
  end

  logic       e;
  logic       nrst;
  logic [3:0] nib;
  assign e    = clk_sync[SYNC_STAGES-1] & ~clk_q;
  assign nrst = rst_sync[SYNC_STAGES-1];
  assign nib  = nib_sync[SYNC_STAGES-1];

  logic is_bad;
  logic is_wr;
  logic is_rd;
  assign is_bad = |nib[1:0];
  assign is_wr  = ~is_bad & nib[3];
  assign is_rd  = ~is_bad & ~nib[3];

  logic [2:0] state;
  logic [7:0] shadow;
  logic [3:0] hold;
  logic       sel;
  logic [7:0] src;
  assign src = nib[2] ? tc : td;

  always_ff @(posedge clk) begin
    if (r_reset) begin
      state     <= IDLE;
      shadow    <= 8'h00;
      hold      <= 4'h0;
      sel       <= 1'b0;
      rd        <= 8'h00;
      rc        <= 8'h00;
      r_nib_o   <= 4'h0;
      r_nib_oe  <= 1'b0;
      rd_wr_stb <= 1'b0;
      rc_wr_stb <= 1'b0;
      td_rd_stb <= 1'b0;
      tc_rd_stb <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_wr_stb <= 1'b0;
      rc_wr_stb <= 1'b0;
      td_rd_stb <= 1'b0;
      tc_rd_stb <= 1'b0;
      if (nrst) begin
        state     <= IDLE;
        r_nib_oe  <= 1'b0;
        frame_err <= 1'b0;
        busy      <= 1'b0;
      end else if (e) begin
        unique case (state)
          IDLE: begin
            sel  <= nib[2];
            busy <= 1'b1;
            unique case (1'b1)
              is_bad: begin
                frame_err <= 1'b1;
                state     <= ERR;
              end
              is_wr: state <= WHI;
              is_rd: begin
                shadow   <= src;
                r_nib_o  <= src[7:4];
                r_nib_oe <= 1'b1;
                state    <= RHI;
              end
              default: state <= IDLE;
            endcase
          end
          RHI: begin
            r_nib_o <= shadow[3:0];
            state   <= RLO;
          end
          RLO: begin
            r_nib_oe  <= 1'b0;
            td_rd_stb <= ~sel;
            tc_rd_stb <= sel;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          WHI: begin
            hold  <= nib;
            state <= WLO;
          end
          WLO: begin
            if (sel) begin
              rc        <= {hold, nib};
              rc_wr_stb <= 1'b1;
            end else begin
              rd        <= {hold, nib};
              rd_wr_stb <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          ERR: state <= ERR;
          default: begin
            r_nib_oe <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tipi_nib_seq.sv
// tb_tipi_nib_seq: random Pi frames against a byte-level model of the TIPI registers.
// Expected strobe events are queued at issue and popped by a separate monitor.
module tb_tipi_nib_seq;

  logic       clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       r_clk = 1'b0;
  logic       r_nibrst = 1'b0;
  logic [3:0] r_nib_i = 4'h0;
  logic [3:0] r_nib_o;
  logic       r_nib_oe;
  logic [7:0] td = 8'h00;
  logic [7:0] tc = 8'h00;
  logic [7:0] rd;
  logic [7:0] rc;
  logic       rd_wr_stb;
  logic       rc_wr_stb;
  logic       td_rd_stb;
  logic       tc_rd_stb;
  logic       busy;
  logic       frame_err;

  tipi_nib_seq #(.SYNC_STAGES(2)) dut (
    .clk(clk), .r_reset(r_reset), .r_clk(r_clk),
    .r_nibrst(r_nibrst), .r_nib_i(r_nib_i),
    .r_nib_o(r_nib_o), .r_nib_oe(r_nib_oe),
    .td(td), .tc(tc), .rd(rd), .rc(rc),
    .rd_wr_stb(rd_wr_stb), .rc_wr_stb(rc_wr_stb),
    .td_rd_stb(td_rd_stb), .tc_rd_stb(tc_rd_stb),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pi_rx = 8'h00;
  logic [7:0] rd_m = 8'h00;
  logic [7:0] rc_m = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: kinds 0=td read,1=tc read,2=rd write,3=rc write
  always @(negedge clk) begin
    int n;
    int k;
    logic [7:0] d;
    exp_t x;
    if (!r_reset) begin
      chk("oe_idle", {31'd0, r_nib_oe & ~busy}, 32'd0);
      n = int'(td_rd_stb) + int'(tc_rd_stb) + int'(rd_wr_stb) + int'(rc_wr_stb);
      if (n > 1) begin
        chk("multi_stb", n, 1);
      end else if (n == 1) begin
        k = td_rd_stb ? 0 : tc_rd_stb ? 1 : rd_wr_stb ? 2 : 3;
        d = (k == 2) ? rd : (k == 3) ? rc : pi_rx;
        if (sb.size() == 0) begin
          chk("unexpected_stb", k, 32'hFF);
        end else begin
          x = sb.pop_front();
          chk("stb_kind", k, x.kind);
          chk("stb_data", {24'd0, d}, {24'd0, x.data});
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] n, output logic [3:0] got,
                         output logic got_oe);
    r_nib_i = n;
    clks(3);
    got = r_nib_o;
    got_oe = r_nib_oe;
  endtask

  task automatic pulse();
    r_clk = 1'b1;
    clks(5);
    r_clk = 1'b0;
    clks(5);
  endtask

  task automatic xfer(input logic [3:0] n);
    logic [3:0] g;
    logic       o;
    present(n, g, o);
    pulse();
  endtask

  task automatic nibrst_pulse();
    r_nibrst = 1'b1;
    clks(6);
    r_nibrst = 1'b0;
    clks(4);
  endtask

  task automatic read_frame(input logic sel, input logic chg);
    logic [3:0] hi;
    logic [3:0] lo;
    logic       o;
    exp_t       x;
    x.kind = sel ? 1 : 0;
    x.data = sel ? tc : td;
    sb.push_back(x);
    xfer({1'b0, sel, 2'b00});
    if (chg) begin
      if (sel) tc = 8'($urandom);
      else td = 8'($urandom);
    end
    present(4'($urandom), hi, o);
    chk("rd_oe_hi", {31'd0, o}, 32'd1);
    pulse();
    present(4'($urandom), lo, o);
    chk("rd_oe_lo", {31'd0, o}, 32'd1);
    pi_rx = {hi, lo};
    pulse();
    chk("rd_oe_end", {31'd0, r_nib_oe}, 32'd0);
  endtask

  task automatic write_frame(input logic sel, input logic [7:0] b);
    exp_t x;
    x.kind = sel ? 3 : 2;
    x.data = b;
    sb.push_back(x);
    xfer({1'b1, sel, 2'b00});
    chk("wr_oe", {31'd0, r_nib_oe}, 32'd0);
    xfer(b[7:4]);
    xfer(b[3:0]);
    if (sel) rc_m = b;
    else rd_m = b;
    chk("wr_rd", {24'd0, rd}, {24'd0, rd_m});
    chk("wr_rc", {24'd0, rc}, {24'd0, rc_m});
  endtask

  task automatic abort_write(input logic sel, input logic two);
    xfer({1'b1, sel, 2'b00});
    if (two) xfer(4'($urandom));
    nibrst_pulse();
    chk("ab_rd", {24'd0, rd}, {24'd0, rd_m});
    chk("ab_rc", {24'd0, rc}, {24'd0, rc_m});
    chk("ab_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic illegal();
    logic [3:0] c;
    c = {2'($urandom), 2'($urandom_range(1, 3))};
    xfer(c);
    chk("il_err", {31'd0, frame_err}, 32'd1);
    chk("il_busy", {31'd0, busy}, 32'd1);
    xfer(4'($urandom));
    xfer(4'($urandom));
    chk("il_oe", {31'd0, r_nib_oe}, 32'd0);
    chk("il_err_hold", {31'd0, frame_err}, 32'd1);
    nibrst_pulse();
    chk("il_err_clr", {31'd0, frame_err}, 32'd0);
    chk("il_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(4);
    chk("rst_rd", {24'd0, rd}, 32'h00);
    chk("rst_rc", {24'd0, rc}, 32'h00);
    chk("rst_oe", {31'd0, r_nib_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    r_reset = 1'b0;
    clks(4);

    write_frame(1'b0, 8'hA5);
    td = 8'h3C;
    read_frame(1'b0, 1'b0);
    tc = 8'h11;
    read_frame(1'b1, 1'b1);
    abort_write(1'b1, 1'b1);
    write_frame(1'b1, 8'hF0);
    illegal();

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 4))
        0: read_frame(1'($urandom), 1'($urandom));
        1: write_frame(1'($urandom), 8'($urandom));
        2: abort_write(1'($urandom), 1'($urandom));
        3: illegal();
        default: begin
          td = 8'($urandom);
          tc = 8'($urandom);
          read_frame(1'($urandom), 1'b0);
        end
      endcase
    end

    // r_reset lands while the final edge of a read frame is in flight
    td = 8'h5A;
    xfer(4'h0);
    xfer(4'h0);
    r_nib_i = 4'h0;
    clks(3);
    r_clk = 1'b1;
    clks(1);
    r_reset = 1'b1;
    clks(8);
    chk("mr_oe", {31'd0, r_nib_oe}, 32'd0);
    chk("mr_rd", {24'd0, rd}, 32'h00);
    chk("mr_rc", {24'd0, rc}, 32'h00);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    r_reset = 1'b0;
    rd_m = 8'h00;
    rc_m = 8'h00;
    r_clk = 1'b0;
    clks(6);
    write_frame(1'b1, 8'h3E);

    clks(10);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tipi_nib_seq.md
Name: tipi_nib_seq

Overview:
- Sequences the 4-bit Pi nibble bus (r_clk, r_nibrst, r_nib) against the four TIPI byte registers: TD and TC are written by the TI and read by the Pi; RD and RC are written by the Pi and read by the TI.
- Each Pi frame is one command nibble followed by two data nibbles, high nibble first.
- Read frames use a snapshot of the source register, so a TI write landing mid-frame cannot tear the byte.
- Sits between the Pi header pins and the TI-side register file in the CPLD top level.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on r_clk, r_nibrst and r_nib_i before use (minimum 2).

Ports:
- clk  in  1  CPLD system clock
- r_reset  in  1  reset r_reset, synchronous, active-high
- r_clk  in  1  Pi nibble strobe, asynchronous; a rising edge transfers one nibble
- r_nibrst  in  1  Pi frame reset, asynchronous, level-active high
- r_nib_i  in  4  nibble from Pi
- r_nib_o  out  4  nibble to Pi
- r_nib_oe  out  1  drive enable for r_nib pads
- td  in  8  TI data register, written by the TI
- tc  in  8  TI control register, written by the TI
- rd  out  8  Pi data register
- rc  out  8  Pi control register
- rd_wr_stb  out  1  one-clk pulse when rd is updated
- rc_wr_stb  out  1  one-clk pulse when rc is updated
- td_rd_stb  out  1  one-clk pulse when a TD read frame completes
- tc_rd_stb  out  1  one-clk pulse when a TC read frame completes
- busy  out  1  high while a frame is in progress
- frame_err  out  1  sticky; set by an illegal command nibble

Behaviour:
- Synchronisation:
  - r_clk, r_nibrst and r_nib_i pass through SYNC_STAGES flops each.
  - One further flop on synced r_clk gives edge pulse e, high for exactly one clk per rising edge.
  - The nibble is sampled as synced r_nib_i in the e cycle.
  - Pi guarantees r_nib_i is stable from 2 clk before to 2 clk after its r_clk rise, and r_clk high/low each ≥ SYNC_STAGES+2 clk.
- Reset (r_reset=1 at a clk edge): state=IDLE, rd=8'h00, rc=8'h00, shadow=8'h00, r_nib_o=0, r_nib_oe=0, all strobes 0, busy=0, frame_err=0.
- Command nibble c[3:0]: 0000 read TD, 0100 read TC, 1000 write RD, 1100 write RC. Any nonzero c[1:0] is illegal.
- States: IDLE, RHI, RLO, WHI, WLO, ERR. All outputs are registered and change in the clk after e.
- IDLE:
  - On e with a legal read command: shadow<=td (or tc), r_nib_o<=shadow-source[7:4], r_nib_oe<=1, goto RHI.
  - On e with a legal write command: goto WHI, r_nib_oe stays 0.
  - On e with an illegal command: frame_err<=1, goto ERR.
- RHI: on e (Pi has captured the high nibble), r_nib_o<=shadow[3:0], goto RLO.
- RLO: on e, r_nib_oe<=0, pulse td_rd_stb (or tc_rd_stb) for 1 clk, goto IDLE.
- WHI: on e, hold<=nibble, goto WLO.
- WLO: on e, rd (or rc)<={hold,nibble}, pulse rd_wr_stb (or rc_wr_stb) in the same clk that rd/rc changes, goto IDLE.
- ERR: ignores e. Exits only on synced r_nibrst or r_reset.
- busy=1 in every state except IDLE.
- Synced r_nibrst=1 (any state, priority over e):
  - goto IDLE, r_nib_oe<=0, frame_err<=0, no strobes.
  - A partial write is discarded; rd and rc are unchanged.
  - While r_nibrst is held, e is ignored.
- td/tc changes after the snapshot do not affect the frame in progress. The next read frame takes the new value.
- r_reset mid-frame overrides everything, including a strobe due in the same clk.
- r_nib_oe is never 1 outside RHI/RLO.

Test Plan:
- Reset, then write-RD frame nibbles 8,A,5 -> rd=8'hA5 after third edge, rd_wr_stb exactly 1 clk, rc=8'h00, r_nib_oe=0 throughout.
- td=8'h3C, read-TD frame 0 -> r_nib_oe=1, r_nib_o=3; next edge -> r_nib_o=C; third edge -> r_nib_oe=0, td_rd_stb 1 clk.
- tc=8'h11, read-TC command, change tc to 8'hEE before second edge -> Pi reads 1,1; next read-TC frame returns E,E.
- Write-RC nibbles C,7, then r_nibrst pulse, then C,F,0 -> rc=8'hF0, no rc_wr_stb for the aborted frame.
- Command 0x1 -> frame_err=1, busy=1, further edges produce no strobes and r_nib_oe=0; r_nibrst -> frame_err=0, IDLE.
- Read-TD frame in RLO with r_reset asserted -> next clk r_nib_oe=0, no td_rd_stb, rd=rc=8'h00.
